// File: rtl/bram_tdp_be.sv
// True dual-port byte-enable block RAM with shared clock.
// Adds post-reset clear sweep, read-during-write modes and collision flag.
module bram_tdp_be #(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int BYTE_WIDTH     = 8,
    parameter int READ_MODE      = 0,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en_a,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] we_a,
    input  logic [ADDR_WIDTH-1:0]            addr_a,
    input  logic [DATA_WIDTH-1:0]            din_a,
    output logic [DATA_WIDTH-1:0]            dout_a,
    output logic                             valid_a,
    input  logic                             en_b,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] we_b,
    input  logic [ADDR_WIDTH-1:0]            addr_b,
    input  logic [DATA_WIDTH-1:0]            din_b,
    output logic [DATA_WIDTH-1:0]            dout_b,
    output logic                             valid_b,
    output logic                             busy,
    output logic                             collision
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   cnt, cnt_nxt;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    act_a, act_b, wr_a, wr_b, ld_a, ld_b, clr;
    logic [DATA_WIDTH-1:0]   wf_a, wf_b, rdata_a, rdata_b;
    logic [DATA_WIDTH-1:0]   hold_a, hold_b, d1_a, d1_b;
    logic                    v1_a, v1_b;

    assign busy  = (state == CLEAR);
    assign clr   = busy & ~rst;
    assign act_a = en_a & ~busy & ~rst;
    assign act_b = en_b & ~busy & ~rst;
    assign wr_a  = act_a & (|we_a);
    assign wr_b  = act_b & (|we_b);
    assign ld_a  = act_a & (~(|we_a) | (READ_MODE != 0));
    assign ld_b  = act_b & (~(|we_b) | (READ_MODE != 0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (state == CLEAR) begin
            cnt_nxt = cnt + 1'b1;
            if (cnt == '1) begin
                state_nxt = IDLE;
            end
        end
    end

    // Post-write word as seen by each port; port B lanes override port A.
    always_comb begin
        wf_a = mem[addr_a];
        wf_b = mem[addr_b];
        for (int i = 0; i < NB; i++) begin
            if (wr_a && we_a[i]) begin
                wf_a[i*BYTE_WIDTH +: BYTE_WIDTH] = din_a[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
            if (wr_b && we_b[i] && addr_a == addr_b) begin
                wf_a[i*BYTE_WIDTH +: BYTE_WIDTH] = din_b[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
            if (wr_a && we_a[i] && addr_a == addr_b) begin
                wf_b[i*BYTE_WIDTH +: BYTE_WIDTH] = din_a[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
            if (wr_b && we_b[i]) begin
                wf_b[i*BYTE_WIDTH +: BYTE_WIDTH] = din_b[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            mem[cnt] <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (wr_a && we_a[i]) begin
                    mem[addr_a][i*BYTE_WIDTH +: BYTE_WIDTH] <= din_a[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
                if (wr_b && we_b[i]) begin
                    mem[addr_b][i*BYTE_WIDTH +: BYTE_WIDTH] <= din_b[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
        if (ld_a) begin
            rdata_a <= (READ_MODE == 2 && wr_a) ? wf_a : mem[addr_a];
        end
        if (ld_b) begin
            rdata_b <= (READ_MODE == 2 && wr_b) ? wf_b : mem[addr_b];
        end
    end

    // Raw read word is unreset; the held copy gives reset value and hold.
    assign d1_a = v1_a ? rdata_a : hold_a;
    assign d1_b = v1_b ? rdata_b : hold_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_a      <= 1'b0;
            v1_b      <= 1'b0;
            hold_a    <= '0;
            hold_b    <= '0;
            collision <= 1'b0;
        end else begin
            v1_a      <= ld_a;
            v1_b      <= ld_b;
            hold_a    <= d1_a;
            hold_b    <= d1_b;
            collision <= act_a & act_b & (addr_a == addr_b) & (wr_a | wr_b);
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic [DATA_WIDTH-1:0] d2_a, d2_b;
        logic                  v2_a, v2_b;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                d2_a <= '0;
                d2_b <= '0;
                v2_a <= 1'b0;
                v2_b <= 1'b0;
            end else begin
                v2_a <= v1_a;
                v2_b <= v1_b;
                if (v1_a) begin
                    d2_a <= d1_a;
                end
                if (v1_b) begin
                    d2_b <= d1_b;
                end
            end
        end

        assign dout_a  = d2_a;
        assign dout_b  = d2_b;
        assign valid_a = v2_a;
        assign valid_b = v2_b;
    end else begin : g_nreg
        assign dout_a  = d1_a;
        assign dout_b  = d1_b;
        assign valid_a = v1_a;
        assign valid_b = v1_b;
    end

endmodule

// File: tb/tb_bram_tdp_be.sv
// Bench for bram_tdp_be: four configurations share one stimulus stream
// and are checked against an array-level reference model.
module tb_bram_tdp_be;
    localparam int NI    = 4;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_a, en_b;
    logic [3:0]  we_a, we_b;
    logic [9:0]  addr_a, addr_b;
    logic [31:0] din_a, din_b;

    logic [31:0] qa [NI];
    logic [31:0] qb [NI];
    logic        va [NI];
    logic        vb [NI];
    logic        bsy [NI];
    logic        col [NI];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        bram_tdp_be #(
            .ADDR_WIDTH(10), .DATA_WIDTH(32), .BYTE_WIDTH(8),
            .READ_MODE(g == 3 ? 1 : g), .OUT_REG(g == 3 ? 1 : 0),
            .CLEAR_ON_RESET(1)
        ) u_dut (
            .clk(clk), .rst(rst),
            .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a),
            .dout_a(qa[g]), .valid_a(va[g]),
            .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b),
            .dout_b(qb[g]), .valid_b(vb[g]),
            .busy(bsy[g]), .collision(col[g])
        );
    end

    // Reference model: whole-word array plus expected output registers.
    logic [31:0] m [DEPTH];
    int          busy_left;
    logic        e_coll;
    logic [31:0] e_d  [NI][2];
    logic        e_v  [NI][2];
    logic [31:0] s1_d [NI][2];
    logic        s1_v [NI][2];

    function automatic int rm_of(int k);
        return (k == 3) ? 1 : k;
    endfunction

    function automatic logic [31:0] pat(int i);
        return 32'hC0DE0000 | 32'(i);
    endfunction

    task automatic model_reset();
        busy_left = DEPTH;
        e_coll    = 1'b0;
        for (int k = 0; k < NI; k++) begin
            for (int p = 0; p < 2; p++) begin
                e_d[k][p]  = '0;
                e_v[k][p]  = 1'b0;
                s1_d[k][p] = '0;
                s1_v[k][p] = 1'b0;
            end
        end
    endtask

    task automatic model_edge();
        logic        act [2];
        logic [3:0]  we [2];
        logic [9:0]  ad [2];
        logic [31:0] dn [2];
        logic [31:0] old [2];
        logic [31:0] fin [2];
        logic        nv;
        logic [31:0] nd;
        logic        bz;
        if (rst) return;
        we[0] = we_a; ad[0] = addr_a; dn[0] = din_a;
        we[1] = we_b; ad[1] = addr_b; dn[1] = din_b;
        bz = (busy_left > 0);
        if (bz) begin
            m[DEPTH - busy_left] = '0;
            busy_left--;
        end
        act[0] = en_a && !bz;
        act[1] = en_b && !bz;
        for (int p = 0; p < 2; p++) old[p] = m[ad[p]];
        for (int p = 0; p < 2; p++) begin
            if (act[p]) begin
                for (int i = 0; i < 4; i++) begin
                    if (we[p][i]) m[ad[p]][8*i +: 8] = dn[p][8*i +: 8];
                end
            end
        end
        for (int p = 0; p < 2; p++) fin[p] = m[ad[p]];
        e_coll = act[0] && act[1] && ad[0] == ad[1] && (we[0] | we[1]) != 0;
        for (int k = 0; k < NI; k++) begin
            for (int p = 0; p < 2; p++) begin
                nv = 1'b0;
                nd = '0;
                if (act[p]) begin
                    if (we[p] == 0) begin
                        nv = 1'b1;
                        nd = old[p];
                    end else if (rm_of(k) != 0) begin
                        nv = 1'b1;
                        nd = (rm_of(k) == 1) ? old[p] : fin[p];
                    end
                end
                if (k == 3) begin
                    e_v[k][p] = s1_v[k][p];
                    if (s1_v[k][p]) e_d[k][p] = s1_d[k][p];
                    s1_v[k][p] = nv;
                    if (nv) s1_d[k][p] = nd;
                end else begin
                    e_v[k][p] = nv;
                    if (nv) e_d[k][p] = nd;
                end
            end
        end
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("m%0d dout_a", k), qa[k], e_d[k][0]);
            chk($sformatf("m%0d dout_b", k), qb[k], e_d[k][1]);
            chk($sformatf("m%0d valid_a", k), 32'(va[k]), 32'(e_v[k][0]));
            chk($sformatf("m%0d valid_b", k), 32'(vb[k]), 32'(e_v[k][1]));
            chk($sformatf("m%0d collision", k), 32'(col[k]), 32'(e_coll));
            chk($sformatf("m%0d busy", k), 32'(bsy[k]), 32'(busy_left > 0));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle();
        en_a = 1'b0; we_a = '0; addr_a = '0; din_a = '0;
        en_b = 1'b0; we_b = '0; addr_b = '0; din_b = '0;
    endtask

    typedef struct {
        logic        en_a;
        logic [3:0]  we_a;
        logic [9:0]  addr_a;
        logic [31:0] din_a;
        logic        en_b;
        logic [3:0]  we_b;
        logic [9:0]  addr_b;
        logic [31:0] din_b;
        logic [31:0] exp_da;
        logic        exp_va;
        logic [31:0] exp_db;
        logic        exp_vb;
        logic        exp_col;
    } vec_t;

    vec_t tbl [11];

    initial begin
        int n;
        int run;
        logic exp_v;

        // Expected results refer to the NO_CHANGE, OUT_REG=0 instance.
        tbl[0]  = '{1'b1, 4'h0, 10'd0,    32'h0,
                    1'b1, 4'h0, 10'd511,  32'h0,
                    32'h0, 1'b1, 32'h0, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 4'h0, 10'd1023, 32'h0,
                    1'b0, 4'h0, 10'd0,    32'h0,
                    32'h0, 1'b1, 32'h0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 4'hF, 10'd5,    32'hAABBCCDD,
                    1'b0, 4'h0, 10'd0,    32'h0,
                    32'h0, 1'b0, 32'h0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 4'h5, 10'd5,    32'h11223344,
                    1'b0, 4'h0, 10'd0,    32'h0,
                    32'h0, 1'b0, 32'h0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 4'h0, 10'd5,    32'h0,
                    1'b1, 4'h0, 10'd5,    32'h0,
                    32'hAA22CC44, 1'b1, 32'hAA22CC44, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 4'h3, 10'd9,    32'h0000FFFF,
                    1'b1, 4'hF, 10'd9,    32'hFFFF0000,
                    32'hAA22CC44, 1'b0, 32'hAA22CC44, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 4'h0, 10'd9,    32'h0,
                    1'b0, 4'h0, 10'd0,    32'h0,
                    32'hFFFF0000, 1'b1, 32'hAA22CC44, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 4'h0, 10'd9,    32'h0,
                    1'b1, 4'hF, 10'd9,    32'h12345678,
                    32'hFFFF0000, 1'b1, 32'hAA22CC44, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 4'h0, 10'd9,    32'h0,
                    1'b1, 4'h0, 10'd10,   32'h0,
                    32'h12345678, 1'b1, 32'h0, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 4'h8, 10'd9,    32'h99000000,
                    1'b1, 4'h0, 10'd9,    32'h0,
                    32'h12345678, 1'b0, 32'h12345678, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 4'h0, 10'd0,    32'h0,
                    1'b1, 4'h0, 10'd9,    32'h0,
                    32'h12345678, 1'b0, 32'h99345678, 1'b1, 1'b0};

        rst = 1'b1;
        idle();
        model_reset();
        repeat (3) step();
        chk("reset busy", 32'(bsy[0]), 32'd1);
        chk("reset dout_a", qa[0], 32'h0);

        // Abort the first sweep part-way through.
        rst = 1'b0;
        repeat (300) step();
        rst = 1'b1;
        model_reset();
        repeat (2) step();
        chk("busy in mid-clear rst", 32'(bsy[0]), 32'd1);
        rst = 1'b0;
        n = 0;
        while (bsy[0] && n < 1100) begin
            step();
            n++;
        end
        chk("clear length", 32'(n), 32'd1024);

        for (int i = 0; i < 11; i++) begin
            en_a = tbl[i].en_a; we_a = tbl[i].we_a;
            addr_a = tbl[i].addr_a; din_a = tbl[i].din_a;
            en_b = tbl[i].en_b; we_b = tbl[i].we_b;
            addr_b = tbl[i].addr_b; din_b = tbl[i].din_b;
            step();
            chk($sformatf("vec%0d dout_a", i), qa[0], tbl[i].exp_da);
            chk($sformatf("vec%0d valid_a", i), 32'(va[0]), 32'(tbl[i].exp_va));
            chk($sformatf("vec%0d dout_b", i), qb[0], tbl[i].exp_db);
            chk($sformatf("vec%0d valid_b", i), 32'(vb[0]), 32'(tbl[i].exp_vb));
            chk($sformatf("vec%0d collision", i), 32'(col[0]), 32'(tbl[i].exp_col));
        end

        // Read-during-write modes on address 7.
        idle();
        en_a = 1'b1;
        step();
        we_a = 4'hF; addr_a = 10'd7; din_a = 32'h1;
        step();
        din_a = 32'h2;
        step();
        chk("nochange dout", qa[0], 32'h0);
        chk("nochange valid", 32'(va[0]), 32'd0);
        chk("readfirst dout", qa[1], 32'h1);
        chk("readfirst valid", 32'(va[1]), 32'd1);
        chk("writefirst dout", qa[2], 32'h2);
        chk("writefirst valid", 32'(va[2]), 32'd1);
        idle();
        step();
        chk("writefirst pulse", 32'(va[2]), 32'd0);

        // OUT_REG=1 read stream on both ports.
        for (int i = 0; i < 8; i++) begin
            en_a = 1'b1; we_a = 4'hF; addr_a = 10'(2*i); din_a = pat(2*i);
            en_b = 1'b1; we_b = 4'hF; addr_b = 10'(2*i+1); din_b = pat(2*i+1);
            step();
        end
        idle();
        repeat (2) step();
        run = 0;
        for (int t = 0; t < 18; t++) begin
            idle();
            if (t < 16) begin
                en_a = 1'b1; addr_a = 10'(t);
                en_b = 1'b1; addr_b = 10'(15 - t);
            end
            step();
            exp_v = (t >= 1 && t <= 16);
            chk($sformatf("oreg t%0d valid_a", t), 32'(va[3]), 32'(exp_v));
            if (exp_v) begin
                chk($sformatf("oreg t%0d dout_a", t), qa[3], pat(t - 1));
                chk($sformatf("oreg t%0d dout_b", t), qb[3], pat(16 - t));
            end
            if (va[3] && vb[3]) run++;
        end
        chk("oreg valid run", 32'(run), 32'd16);

        // Random traffic over a small address window to force conflicts.
        for (int c = 0; c < 4000; c++) begin
            en_a = ($urandom_range(0, 3) != 0);
            we_a = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
            addr_a = 10'($urandom_range(0, 15));
            din_a = $urandom;
            en_b = ($urandom_range(0, 3) != 0);
            we_b = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
            addr_b = 10'($urandom_range(0, 15));
            din_b = $urandom;
            step();
        end
        idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
